// File: rtl/sat_mult_seq.sv
// sat_mult_seq: iterative shift-and-add unsigned multiplier, saturating to OUT_WIDTH bits.
// Define SAT_MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module sat_mult_seq #(
    parameter int A_WIDTH   = 32,
    parameter int B_WIDTH   = 8,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 sat
);
    localparam int W  = A_WIDTH + B_WIDTH;
    localparam int CW = $clog2(B_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state_q, state_d;
    logic [W-1:0]           mcand_q, mcand_d, acc_q, acc_d, acc_sum;
    logic [B_WIDTH-1:0]     mult_q, mult_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]   dout_q, dout_d;
    logic                   sat_q, sat_d, last;

    generate
        if (OUT_WIDTH > W) begin : g_width_chk
            $error("sat_mult_seq: OUT_WIDTH must not exceed A_WIDTH+B_WIDTH");
        end
    endgenerate

    assign acc_sum = mult_q[0] ? acc_q + mcand_q : acc_q;
`ifdef SAT_MULT_EARLY_EXIT_EN
    assign last = (mult_q >> 1) == '0;
`else
    assign last = cnt_q == CW'(B_WIDTH - 1);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mcand_q <= '0;
            mult_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mult_q  <= mult_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mult_d  = mult_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: if (in_valid) begin
                mcand_d = W'(a);
                mult_d  = b;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                acc_d   = acc_sum;
                mcand_d = mcand_q << 1;
                mult_d  = mult_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                // anything above OUT_WIDTH in the final sum means the product overflowed
                if (last) begin
                    state_d = DONE;
                    sat_d   = |(acc_sum >> OUT_WIDTH);
                    dout_d  = sat_d ? '1 : acc_sum[OUT_WIDTH-1:0];
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign dout      = dout_q;
    assign sat       = sat_q;
endmodule

// File: tb/tb_sat_mult_seq.sv
// tb_sat_mult_seq: directed and randomized checks of sat_mult_seq against an arithmetic reference.
module tb_sat_mult_seq;
    logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, sat;
    logic [31:0] a = '0, dout;
    logic [7:0]  b = '0;
    int          total = 0, bad = 0;

    sat_mult_seq dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .sat(sat)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [7:0] y);
        return {32'd0, x} * {56'd0, y};
    endfunction

    function automatic int ref_lat(input logic [7:0] y);
`ifdef SAT_MULT_EARLY_EXIT_EN
        int l = 1;
        for (int i = 0; i < 8; i++) if (y[i]) l = i + 1;
        return l;
`else
        return 8;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 999;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] x, input logic [7:0] y, input int lat);
        logic [63:0] p = ref_prod(x, y);
        logic        s = p > 64'hFFFF_FFFF;
        chk({tag, "_dout"}, dout, s ? 64'hFFFF_FFFF : p);
        chk({tag, "_sat"}, sat, s);
        chk({tag, "_lat"}, lat, ref_lat(y));
    endtask

    // Called #1 after a rising edge with the DUT idle.
    task automatic op(input string tag, input logic [31:0] x, input logic [7:0] y);
        int lat;
        a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = 8'($urandom);
        chk({tag, "_busy_rdy"}, in_ready, 0);
        wait_out(lat);
        check_result(tag, x, y, lat);
        @(posedge clk); #1;
        chk({tag, "_ov_drop"}, out_valid, 0);
        chk({tag, "_idle_rdy"}, in_ready, 1);
    endtask

    initial begin
        int lat;
        logic [31:0] ra;
        logic [7:0]  rb;
        #2;
        chk("rst_ov", out_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_sat", sat, 0);
        chk("rst_rdy", in_ready, 1);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        op("basic", 32'd1000, 8'd25);
        op("sat_x2", 32'hFFFF_FFFF, 8'd2);
        op("max_x1", 32'hFFFF_FFFF, 8'd1);
        op("msb_x1", 32'h8000_0000, 8'd1);
        op("pow32", 32'h8000_0000, 8'd2);
        op("b_zero", 32'd123, 8'd0);
        op("a_zero", 32'd0, 8'd255);
        op("b_three", 32'd77, 8'h03);

        // stall the output, with the next operands already waiting
        a = 32'd7; b = 8'd9; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        a = 32'd3; b = 8'd3;
        wait_out(lat);
        check_result("hold", 32'd7, 8'd9, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_dout", dout, 63);
            chk("hold_ov", out_valid, 1);
            chk("hold_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_ov", out_valid, 0);
        chk("hs_rdy", in_ready, 1);
        chk("hs_dout_kept", dout, 63);
        @(posedge clk); #1;
        chk("b2b_accept", in_ready, 0);
        in_valid = 1'b0;
        wait_out(lat);
        check_result("b2b", 32'd3, 8'd3, lat);
        @(posedge clk); #1;

        // reset while busy
        a = 32'd200; b = 8'd255; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_ov", out_valid, 0);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_sat", sat, 0);
        chk("mid_rst_rdy", in_ready, 1);
        @(posedge clk); #1 reset = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            chk("post_rst_ov", out_valid, 0);
        end
        op("after_rst", 32'd5, 8'd5);

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = 8'($urandom);
            if (i % 3 == 0) ra = ra >> $urandom_range(31, 20);
            if (i % 4 == 1) rb = rb >> $urandom_range(7, 3);
            op("rand", ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
